// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and types for the register file with write-reservation scoreboard.
package regfile_scoreboard_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NREAD      = 2;
    localparam int DEF_PEND_WIDTH = 2;

    typedef logic [DEF_ADDR_WIDTH-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: register select, writeback forwarding and operand-ready.
module regfile_read_port #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int PEND_WIDTH = 2,
    parameter int BYPASS     = 1
) (
    input  logic [ADDR_WIDTH-1:0]                   raddr,
    input  logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]   rf_flat,
    input  logic [(2**ADDR_WIDTH)*PEND_WIDTH-1:0]   pend_flat,
    input  logic                                    fwd_valid,
    input  logic [ADDR_WIDTH-1:0]                   wb_rd,
    input  logic [DATA_WIDTH-1:0]                   wb_data,
    input  logic                                    issue_acc,
    input  logic [ADDR_WIDTH-1:0]                   issue_rd,
    output logic [DATA_WIDTH-1:0]                   rdata,
    output logic                                    rready
);

    logic [DATA_WIDTH-1:0] stored;
    logic [PEND_WIDTH-1:0] pend;
    logic                  fwd_hit;

    assign stored  = rf_flat[int'(raddr)*DATA_WIDTH +: DATA_WIDTH];
    assign pend    = pend_flat[int'(raddr)*PEND_WIDTH +: PEND_WIDTH];
    assign fwd_hit = (BYPASS != 0) && fwd_valid && (wb_rd == raddr) && (raddr != '0);
    assign rdata   = fwd_hit ? wb_data : stored;

    // A retiring write makes the operand ready only if it is the last one outstanding
    // and no new reservation for the same register lands in this cycle.
    assign rready  = (pend == '0) ||
                     (fwd_hit && (pend == PEND_WIDTH'(1)) && !(issue_acc && (issue_rd == raddr)));

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-write counters, flush and sticky protocol error.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NREAD      = DEF_NREAD,
    parameter int PEND_WIDTH = DEF_PEND_WIDTH,
    parameter int BYPASS     = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
    output logic [NREAD*DATA_WIDTH-1:0] rdata,
    output logic [NREAD-1:0]            rready,
    input  logic                        issue_valid,
    input  logic [ADDR_WIDTH-1:0]       issue_rd,
    output logic                        issue_ready,
    input  logic                        wb_valid,
    input  logic [ADDR_WIDTH-1:0]       wb_rd,
    input  logic [DATA_WIDTH-1:0]       wb_data,
    input  logic                        flush,
    output logic                        err
);

    localparam int NREGS = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]       rf   [NREGS];
    logic [PEND_WIDTH-1:0]       pend [NREGS];
    logic [NREGS*DATA_WIDTH-1:0] rf_flat;
    logic [NREGS*PEND_WIDTH-1:0] pend_flat;
    logic                        issue_acc;
    logic                        wb_write;
    logic                        wb_same_issue;
    logic                        err_set;
    logic                        fwd_valid;

    always_comb begin
        rf_flat   = '0;
        pend_flat = '0;
        for (int r = 0; r < NREGS; r++) begin
            rf_flat[r*DATA_WIDTH +: DATA_WIDTH]   = rf[r];
            pend_flat[r*PEND_WIDTH +: PEND_WIDTH] = pend[r];
        end
    end

    // A full counter can still take a reservation when a writeback to it retires in the same cycle.
    assign issue_ready   = !((issue_rd != '0) && (pend[issue_rd] == '1) &&
                             !(wb_valid && (wb_rd == issue_rd)));
    assign issue_acc     = issue_valid && issue_ready && (issue_rd != '0);
    assign wb_write      = wb_valid && (wb_rd != '0);
    assign wb_same_issue = issue_acc && (issue_rd == wb_rd);
    assign err_set       = (issue_valid && !issue_ready) ||
                           (wb_write && (pend[wb_rd] == '0) && !wb_same_issue);
    assign fwd_valid     = wb_valid && reset;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) begin
                rf[r]   <= '0;
                pend[r] <= '0;
            end
            err <= 1'b0;
        end else begin
            if (wb_write) begin
                rf[wb_rd] <= wb_data;
            end
            for (int r = 1; r < NREGS; r++) begin
                if (flush) begin
                    pend[r] <= '0;
                end else if (issue_acc && (issue_rd == ADDR_WIDTH'(r))) begin
                    if (!(wb_valid && (wb_rd == ADDR_WIDTH'(r)))) begin
                        pend[r] <= pend[r] + PEND_WIDTH'(1);
                    end
                end else if (wb_valid && (wb_rd == ADDR_WIDTH'(r)) && (pend[r] != '0)) begin
                    pend[r] <= pend[r] - PEND_WIDTH'(1);
                end
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_read
        regfile_read_port #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .PEND_WIDTH (PEND_WIDTH),
            .BYPASS     (BYPASS)
        ) u_port (
            .raddr     (raddr[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .rf_flat   (rf_flat),
            .pend_flat (pend_flat),
            .fwd_valid (fwd_valid),
            .wb_rd     (wb_rd),
            .wb_data   (wb_data),
            .issue_acc (issue_acc),
            .issue_rd  (issue_rd),
            .rdata     (rdata[i*DATA_WIDTH +: DATA_WIDTH]),
            .rready    (rready[i])
        );
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed vector bench for regfile_scoreboard with default parameters.
module tb_regfile_scoreboard;
    import regfile_scoreboard_pkg::*;

    localparam int AW = DEF_ADDR_WIDTH;
    localparam int DW = DEF_DATA_WIDTH;
    localparam int NR = DEF_NREAD;

    logic             clock = 1'b0;
    logic             reset;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rready;
    logic             issue_valid;
    logic [AW-1:0]    issue_rd;
    logic             issue_ready;
    logic             wb_valid;
    logic [AW-1:0]    wb_rd;
    logic [DW-1:0]    wb_data;
    logic             flush;
    logic             err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        iv;
        reg_idx_t    ird;
        logic        wv;
        reg_idx_t    wrd;
        logic [31:0] wd;
        reg_idx_t    ra0;
        reg_idx_t    ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  erdy;
        logic        eir;
        logic        eerr;
    } vec_t;

    vec_t vecs [9];

    regfile_scoreboard #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NREAD      (NR),
        .PEND_WIDTH (2),
        .BYPASS     (1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .raddr       (raddr),
        .rdata       (rdata),
        .rready      (rready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .flush       (flush),
        .err         (err)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drives one cycle's inputs just after the falling edge; outputs are checked mid-cycle.
    task automatic apply_stimulus(input logic iv, input reg_idx_t ird, input logic wv,
                                  input reg_idx_t wrd, input logic [31:0] wd, input logic fl,
                                  input reg_idx_t a0, input reg_idx_t a1);
        @(negedge clock);
        issue_valid = iv;
        issue_rd    = ird;
        wb_valid    = wv;
        wb_rd       = wrd;
        wb_data     = wd;
        flush       = fl;
        raddr       = {a1, a0};
        #2;
    endtask

    task automatic do_reset();
        @(negedge clock);
        issue_valid = 1'b0;
        issue_rd    = '0;
        wb_valid    = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
        flush       = 1'b0;
        reset       = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        5'd1, 5'd2, 32'h0,        32'h0,        2'b11, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 5'd1, 1'b0, 5'd0, 32'h0,        5'd1, 5'd0, 32'h0,        32'h0,        2'b11, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 5'd2, 1'b0, 5'd0, 32'h0,        5'd1, 5'd2, 32'h0,        32'h0,        2'b10, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 5'd0, 1'b1, 5'd1, 32'hCAFE0001, 5'd1, 5'd2, 32'hCAFE0001, 32'h0,        2'b01, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        5'd1, 5'd2, 32'hCAFE0001, 32'h0,        2'b01, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 5'd2, 1'b1, 5'd2, 32'h22222222, 5'd2, 5'd1, 32'h22222222, 32'hCAFE0001, 2'b10, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        5'd2, 5'd2, 32'h22222222, 32'h22222222, 2'b00, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 5'd0, 1'b1, 5'd2, 32'h33333333, 5'd2, 5'd0, 32'h33333333, 32'h0,        2'b11, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        5'd2, 5'd1, 32'h33333333, 32'hCAFE0001, 2'b11, 1'b1, 1'b0};

        reset       = 1'b0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        wb_valid    = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
        flush       = 1'b0;
        raddr       = {5'd2, 5'd1};
        #2;
        check_output("reset_rdata0", rdata[31:0], 32'h0);
        check_output("reset_rdata1", rdata[63:32], 32'h0);
        check_output("reset_rready", {30'h0, rready}, 32'h3);
        check_output("reset_issue_ready", {31'h0, issue_ready}, 32'h1);
        check_output("reset_err", {31'h0, err}, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        $display("[TB] table vectors");
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i].iv, vecs[i].ird, vecs[i].wv, vecs[i].wrd, vecs[i].wd, 1'b0,
                           vecs[i].ra0, vecs[i].ra1);
            check_output($sformatf("vec%0d_rdata0", i), rdata[31:0], vecs[i].e0);
            check_output($sformatf("vec%0d_rdata1", i), rdata[63:32], vecs[i].e1);
            check_output($sformatf("vec%0d_rready", i), {30'h0, rready}, {30'h0, vecs[i].erdy});
            check_output($sformatf("vec%0d_issue_ready", i), {31'h0, issue_ready}, {31'h0, vecs[i].eir});
            check_output($sformatf("vec%0d_err", i), {31'h0, err}, {31'h0, vecs[i].eerr});
        end

        $display("[TB] writeback without reservation");
        do_reset();
        apply_stimulus(1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0);
        check_output("wb_noissue_err_before", {31'h0, err}, 32'h0);
        apply_stimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0);
        check_output("wb_noissue_rdata", rdata[31:0], 32'hDEADBEEF);
        check_output("wb_noissue_err", {31'h0, err}, 32'h1);
        check_output("wb_noissue_rready", {31'h0, rready[0]}, 32'h1);

        $display("[TB] saturated pending counter");
        do_reset();
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0);
            check_output($sformatf("sat_issue%0d_ready", k), {31'h0, issue_ready}, 32'h1);
        end
        apply_stimulus(1'b0, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0);
        check_output("sat_full_issue_ready", {31'h0, issue_ready}, 32'h0);
        check_output("sat_full_rready", {31'h0, rready[0]}, 32'h0);
        apply_stimulus(1'b1, 5'd7, 1'b1, 5'd7, 32'h00000077, 1'b0, 5'd7, 5'd0);
        check_output("sat_issue_wb_ready", {31'h0, issue_ready}, 32'h1);
        check_output("sat_issue_wb_rdata", rdata[31:0], 32'h00000077);
        check_output("sat_issue_wb_rready", {31'h0, rready[0]}, 32'h0);
        apply_stimulus(1'b0, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0);
        check_output("sat_still_full", {31'h0, issue_ready}, 32'h0);
        check_output("sat_no_err", {31'h0, err}, 32'h0);
        check_output("sat_rf_written", rdata[31:0], 32'h00000077);
        apply_stimulus(1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0);
        apply_stimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0);
        check_output("sat_reject_err", {31'h0, err}, 32'h1);
        for (int k = 0; k < 2; k++) begin
            apply_stimulus(1'b0, 5'd0, 1'b1, 5'd7, 32'h70 + k, 1'b0, 5'd7, 5'd0);
        end
        apply_stimulus(1'b0, 5'd0, 1'b1, 5'd7, 32'h7F, 1'b0, 5'd7, 5'd0);
        check_output("sat_last_wb_rready", {31'h0, rready[0]}, 32'h1);

        $display("[TB] register zero");
        do_reset();
        apply_stimulus(1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
        check_output("x0_same_rdata", rdata[31:0], 32'h0);
        check_output("x0_same_rready", {31'h0, rready[0]}, 32'h1);
        apply_stimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        check_output("x0_rdata", rdata[31:0], 32'h0);
        check_output("x0_rready", {31'h0, rready[0]}, 32'h1);
        check_output("x0_err", {31'h0, err}, 32'h0);

        $display("[TB] flush");
        do_reset();
        apply_stimulus(1'b1, 5'd1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 5'd2);
        apply_stimulus(1'b1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 5'd2);
        apply_stimulus(1'b1, 5'd3, 1'b1, 5'd1, 32'h000000A5, 1'b1, 5'd1, 5'd2);
        apply_stimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 5'd2);
        check_output("flush_rdata_x1", rdata[31:0], 32'h000000A5);
        check_output("flush_rready", {30'h0, rready}, 32'h3);
        check_output("flush_err", {31'h0, err}, 32'h0);
        apply_stimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd0);
        check_output("flush_overrides_issue", {31'h0, rready[0]}, 32'h1);

        $display("[TB] reset mid-sequence");
        do_reset();
        apply_stimulus(1'b0, 5'd0, 1'b1, 5'd9, 32'h9, 1'b0, 5'd4, 5'd0);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b1, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd0);
        end
        apply_stimulus(1'b0, 5'd0, 1'b1, 5'd4, 32'h00000044, 1'b0, 5'd4, 5'd0);
        apply_stimulus(1'b0, 5'd4, 1'b1, 5'd4, 32'h00000099, 1'b0, 5'd4, 5'd0);
        check_output("pre_reset_err", {31'h0, err}, 32'h1);
        reset = 1'b0;
        #1;
        check_output("midreset_rdata", rdata[31:0], 32'h0);
        check_output("midreset_rready", {30'h0, rready}, 32'h3);
        check_output("midreset_issue_ready", {31'h0, issue_ready}, 32'h1);
        check_output("midreset_err", {31'h0, err}, 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset       = 1'b1;
        issue_valid = 1'b1;
        issue_rd    = 5'd6;
        wb_valid    = 1'b1;
        wb_rd       = 5'd6;
        wb_data     = 32'h00000066;
        raddr       = {5'd0, 5'd4};
        #2;
        apply_stimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd6, 5'd4);
        check_output("release_wb_rdata", rdata[31:0], 32'h00000066);
        check_output("release_rready", {30'h0, rready}, 32'h3);
        check_output("release_x4_cleared", rdata[63:32], 32'h0);
        check_output("release_err", {31'h0, err}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, meaning register index width; 2**ADDR_WIDTH registers.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning register width.
REQ-003 SHALL have parameter NREAD, default 2, meaning number of read ports.
REQ-004 SHALL have parameter PEND_WIDTH, default 2, meaning per-register pending-write counter width.
REQ-005 SHALL have parameter BYPASS, default 1, meaning same-cycle writeback forwarding to read ports is enabled.
REQ-006 Ports: clock  in  1  sole clock; all state on posedge clock.
REQ-007 Ports: reset  in  1  asynchronous, active-low reset.
REQ-008 Ports: raddr  in  NREAD*ADDR_WIDTH  packed read indices; port i uses slice i.
REQ-009 Ports: rdata  out  NREAD*DATA_WIDTH  packed read data.
REQ-010 Ports: rready  out  NREAD  port i operand has no outstanding write.
REQ-011 Ports: issue_valid, issue_rd  in  1, ADDR_WIDTH  reserve a future write to issue_rd.
REQ-012 Ports: issue_ready  out  1  reservation can be accepted this cycle.
REQ-013 Ports: wb_valid, wb_rd, wb_data  in  1, ADDR_WIDTH, DATA_WIDTH  writeback retiring one reservation.
REQ-014 Ports: flush  in  1  clears all reservations.
REQ-015 Ports: err  out  1  sticky protocol-error flag.

Function
REQ-016 Register 0 SHALL always read 0; writes and reservations to index 0 SHALL be ignored; rready for index 0 SHALL be 1.
REQ-017 Reads SHALL be combinational: rdata[i] = rf[raddr[i]], except with BYPASS=1 and wb_valid with wb_rd==raddr[i]!=0, rdata[i] = wb_data.
REQ-018 Each register r SHALL have a counter pend[r] of PEND_WIDTH bits.
REQ-019 rready[i] SHALL be 1 iff pend[raddr[i]]==0, or BYPASS=1 and wb_valid, wb_rd==raddr[i], pend==1, and no same-cycle issue to that register.
REQ-020 issue_ready SHALL be 0 iff issue_rd!=0 and pend[issue_rd] is at maximum (2**PEND_WIDTH-1) and no same-cycle writeback to issue_rd; otherwise 1.
REQ-021 Issue accepted (issue_valid & issue_ready, rd!=0) SHALL increment pend[issue_rd] on the next edge.
REQ-022 wb_valid with wb_rd!=0 SHALL write wb_data to rf[wb_rd] and decrement pend[wb_rd] on the next edge.
REQ-023 Simultaneous accepted issue and writeback to the same register SHALL leave pend unchanged and still write data.
REQ-024 Writeback to a register with pend==0 SHALL write data, leave pend at 0 (no underflow), and set err.
REQ-025 issue_valid while issue_ready==0 SHALL not change state and SHALL set err.
REQ-026 flush SHALL zero all pend counters on the next edge, overriding same-cycle issue; a same-cycle writeback SHALL still update rf.
REQ-027 err SHALL remain 1 until reset.

Reset
REQ-028 While reset==0, all rf entries, all pend counters and err SHALL be 0 asynchronously.
REQ-029 During reset, rdata SHALL be 0 for all ports, rready all 1, issue_ready 1.
REQ-030 Reset deassertion SHALL take effect at the first posedge clock after release; issue/wb presented in that cycle SHALL be honoured.

Structure
REQ-031 A shared package SHALL hold default ADDR_WIDTH/DATA_WIDTH/NREAD constants and a register-index typedef.
REQ-032 Read-port mux plus bypass SHALL be one sub-module, regfile_read_port, instantiated NREAD times via generate.

Verification
REQ-033 Reset, wb x5=0xDEADBEEF without prior issue -> next cycle rdata(x5)=0xDEADBEEF, err=1.
REQ-034 Issue x3; next cycle read x3 -> rready=0; wb x3=0x12345678 same cycle as read -> rdata=0x12345678, rready=1 (BYPASS=1).
REQ-035 Issue x7 three times (PEND_WIDTH=2) -> issue_ready=0 for x7; 4th issue with concurrent wb x7 -> accepted, pend stays 3, err=0.
REQ-036 wb x0=0xFFFFFFFF, issue x0 -> rdata(x0)=0, rready=1, err=0.
REQ-037 Issue x1,x2; flush with concurrent wb x1=0xA5 -> pend all 0, rf[x1]=0xA5, rready both 1.
REQ-038 Assert reset mid-sequence with pend[x4]=2 -> immediately rdata(x4)=0, rready=1, err=0.
